// File: rtl/tube_fifo_reader.sv
// tube_fifo_reader: drains the drift-tube event FIFO, checks tag order, streams hit records
//
// Sits on the FIFO read clock in front of the RPi-facing logic. Idle filler words are
// dropped. Each event is 32 words, one per tube, in the fixed tag order. Each good word
// becomes one hit record on a valid/ready stream. A sequence error aborts the event.
//
// Ports:
//   clk          FIFO read clock
//   clr_n        asynchronous active-low reset
//   fifo_dout    FIFO read data, [15:8] hit time, [7:0] tube tag
//   fifo_empty   FIFO empty
//   fifo_valid   fifo_dout valid, one cycle after fifo_rd_en
//   fifo_rd_en   FIFO read enable
//   hit_valid    hit record valid
//   hit_ready    downstream accepts the record
//   hit_tube     tube index 0..31
//   hit_time     hit time, 0 = no hit
//   hit_last     record is tube 31 of the event
//   evt_done     one-cycle pulse when an event completes cleanly
//   evt_mask     per-tube nonzero-time mask of the last clean event
//   evt_count    completed events, wraps
//   seq_err      one-cycle pulse on a tag sequence error
//   err_count    sequence errors, saturates
//
// Build option: define ZERO_SUPPRESS_EN to drop records with hit_time == 0. The tube 31
// record is always emitted because it carries hit_last.
module tube_fifo_reader #(
    parameter logic [15:0] IDLE_WORD = 16'h00FF,
    parameter int          EVT_WORDS = 32,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [15:0]      fifo_dout,
    input  logic             fifo_empty,
    input  logic             fifo_valid,
    output logic             fifo_rd_en,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [4:0]       hit_tube,
    output logic [7:0]       hit_time,
    output logic             hit_last,
    output logic             evt_done,
    output logic [31:0]      evt_mask,
    output logic [CNT_W-1:0] evt_count,
    output logic             seq_err,
    output logic [CNT_W-1:0] err_count
);
    localparam logic [4:0] LAST = 5'(EVT_WORDS - 1);

    typedef enum logic {HUNT = 1'b0, EVENT = 1'b1} state_t;

    state_t      state, state_nx;
    logic [4:0]  seq, seq_nx;
    logic [31:0] mask_acc, mask_nx;
    logic [1:0]  skid_cnt, occ_after;
    logic        in_flight;
    logic [15:0] skid0, skid1;
    logic        out_free, pop, push;
    logic [7:0]  w_tag, w_time, exp_tag;
    logic [4:0]  w_tube;
    logic        w_idle, w_nz, is_c0, match, start, adv, err, done, emit;

    // The output register is free when it is empty or being accepted this cycle.
    // A word is consumed from the skid head only then.
    assign out_free  = !hit_valid || hit_ready;
    assign pop       = (skid_cnt != 2'd0) && out_free;
    assign push      = fifo_valid;
    assign occ_after = skid_cnt - {1'b0, pop};

    // Occupancy is counted after this cycle's pop. A word read now lands next cycle,
    // when at most one entry is held, so the buffer never overflows. One read per
    // cycle is still possible while the head drains every cycle.
    assign fifo_rd_en = clr_n && !fifo_empty && (({1'b0, occ_after} + {2'b0, in_flight}) < 3'd2);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            skid_cnt  <= 2'd0;
            in_flight <= 1'b0;
            skid0     <= 16'h0;
            skid1     <= 16'h0;
        end else begin
            skid_cnt  <= occ_after + {1'b0, push};
            in_flight <= fifo_rd_en;
            skid0     <= (push && occ_after == 2'd0) ? fifo_dout : (pop ? skid1 : skid0);
            skid1     <= (push && occ_after == 2'd1) ? fifo_dout : skid1;
        end
    end

    // Head word decode. The wire number in the tag is bit-reversed.
    assign w_tag   = skid0[7:0];
    assign w_time  = skid0[15:8];
    assign w_idle  = skid0 == IDLE_WORD;
    assign w_nz    = |w_time;
    assign w_tube  = {w_tag[7:4] == 4'b0010, w_tag[3], w_tag[0], w_tag[1], w_tag[2]};
    assign exp_tag = {seq[4] ? 4'b0010 : 4'b1100, seq[3], seq[0], seq[1], seq[2]};

    // FSM state register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= HUNT;
            seq      <= 5'd0;
            mask_acc <= 32'h0;
        end else begin
            state    <= state_nx;
            seq      <= seq_nx;
            mask_acc <= (start || adv) ? mask_nx : mask_acc;
        end
    end

    // FSM next state. A C0 always starts a new event, even one that aborts the current event.
    always_comb begin
        state_nx = state;
        if (pop)
            state_nx = start ? EVENT : ((done || err) ? HUNT : state);
    end

    // FSM outputs for the word being consumed
    always_comb begin
        is_c0   = !w_idle && w_tag == 8'hC0;
        match   = state == EVENT && !w_idle && w_tag == exp_tag;
        start   = pop && is_c0 && !match;
        adv     = pop && match;
        err     = pop && state == EVENT && !match;
        done    = adv && seq == LAST;
        seq_nx  = start ? 5'd1 : (adv ? seq + 5'd1 : seq);
        mask_nx = start ? {31'b0, w_nz} : (mask_acc | ({31'b0, w_nz} << seq));
`ifdef ZERO_SUPPRESS_EN
        emit    = (start || adv) && (w_nz || done);
`else
        emit    = start || adv;
`endif
    end

    // Registered output stream and event bookkeeping
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hit_valid <= 1'b0;
            hit_tube  <= 5'd0;
            hit_time  <= 8'd0;
            hit_last  <= 1'b0;
            evt_done  <= 1'b0;
            seq_err   <= 1'b0;
            evt_mask  <= 32'h0;
            evt_count <= '0;
            err_count <= '0;
        end else begin
            hit_valid <= emit ? 1'b1 : (hit_ready ? 1'b0 : hit_valid);
            hit_tube  <= emit ? w_tube : hit_tube;
            hit_time  <= emit ? w_time : hit_time;
            hit_last  <= emit ? done : hit_last;
            evt_done  <= done;
            seq_err   <= err;
            evt_mask  <= done ? mask_nx : evt_mask;
            evt_count <= done ? evt_count + CNT_W'(1) : evt_count;
            err_count <= (err && !(&err_count)) ? err_count + CNT_W'(1) : err_count;
        end
    end
endmodule

// File: tb/tb_tube_fifo_reader.sv
// tb_tube_fifo_reader: directed table-driven bench for tube_fifo_reader
module tb_tube_fifo_reader;
    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [15:0] fifo_dout = 16'h0;
    logic        fifo_empty;
    logic        fifo_valid = 1'b0;
    logic        fifo_rd_en;
    logic        hit_valid;
    logic        hit_ready = 1'b1;
    logic [4:0]  hit_tube;
    logic [7:0]  hit_time;
    logic        hit_last;
    logic        evt_done;
    logic [31:0] evt_mask;
    logic [15:0] evt_count;
    logic        seq_err;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    tube_fifo_reader dut (
        .clk(clk), .clr_n(clr_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_valid(fifo_valid), .fifo_rd_en(fifo_rd_en), .hit_valid(hit_valid),
        .hit_ready(hit_ready), .hit_tube(hit_tube), .hit_time(hit_time), .hit_last(hit_last),
        .evt_done(evt_done), .evt_mask(evt_mask), .evt_count(evt_count), .seq_err(seq_err),
        .err_count(err_count)
    );

    logic [7:0] tags [32] = '{8'hC0, 8'hC4, 8'hC2, 8'hC6, 8'hC1, 8'hC5, 8'hC3, 8'hC7,
                              8'hC8, 8'hCC, 8'hCA, 8'hCE, 8'hC9, 8'hCD, 8'hCB, 8'hCF,
                              8'h20, 8'h24, 8'h22, 8'h26, 8'h21, 8'h25, 8'h23, 8'h27,
                              8'h28, 8'h2C, 8'h2A, 8'h2E, 8'h29, 8'h2D, 8'h2B, 8'h2F};

    logic [15:0] mem [0:4095];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        fifo_valid <= fifo_rd_en && !fifo_empty;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rp];
            rp <= rp + 1;
        end
    end

    int nrec = 0, ndone = 0, nerr = 0, nrd = 0;
    int tog = 0;
    logic [4:0] r_tube [0:1023];
    logic [7:0] r_time [0:1023];
    logic       r_last [0:1023];

    always @(negedge clk) begin
        hit_ready = (tog != 0) ? !hit_ready : 1'b1;
        if (hit_valid && hit_ready && nrec < 1024) begin
            r_tube[nrec] = hit_tube;
            r_time[nrec] = hit_time;
            r_last[nrec] = hit_last;
            nrec++;
        end
        if (evt_done) ndone++;
        if (seq_err) nerr++;
        if (fifo_valid) nrd++;
    end

    int n_chk = 0, n_fail = 0;
    int ne;
    logic [4:0] e_tube [0:255];
    logic [7:0] e_time [0:255];
    logic       e_last [0:255];
    int b_rec, b_done, b_err, b_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        mem[wp] = w;
        wp++;
    endtask

    task automatic add_exp(input int t, input int tm, input bit l);
        e_tube[ne] = 5'(t);
        e_time[ne] = 8'(tm);
        e_last[ne] = l;
        ne++;
    endtask

    task automatic clean_event(input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            push_word({8'(i + 1), tags[i]});
            add_exp(i, i + 1, i == 31);
        end
    endtask

    task automatic gen(input int pat);
        logic [7:0] tm;
        ne = 0;
        if (pat == 0) begin
            repeat (10) push_word(16'h00FF);
        end else begin
            push_word(16'h00FF);
            push_word(16'h00FF);
            if (pat == 1) clean_event(0, 32);
            if (pat == 2) begin
                for (int i = 0; i < 32; i++) push_word({8'(i + 1), (i == 1) ? 8'h2F : tags[i]});
                add_exp(0, 1, 1'b0);
            end
            if (pat == 3) begin
                for (int i = 0; i < 32; i++) begin
                    tm = (i == 3) ? 8'h12 : ((i == 20) ? 8'h80 : 8'h00);
                    push_word({tm, tags[i]});
`ifdef ZERO_SUPPRESS_EN
                    if (tm != 8'h00 || i == 31) add_exp(i, int'(tm), i == 31);
`else
                    add_exp(i, int'(tm), i == 31);
`endif
                end
            end
            if (pat == 4) begin
                clean_event(0, 16);
                clean_event(0, 32);
            end
        end
    endtask

    task automatic snap();
        b_rec = nrec;
        b_done = ndone;
        b_err = nerr;
        b_rd = nrd;
    endtask

    task automatic drain();
        int c = 0;
        while (wp != rp && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (wp != rp) chk("drain_timeout", 32'(wp - rp), 32'd0);
        repeat (12) @(negedge clk);
    endtask

    task automatic chk_records(input string nm);
        int bad = 0;
        for (int j = 0; j < ne; j++) begin
            if (b_rec + j >= nrec) begin
                bad++;
            end else if (r_tube[b_rec + j] !== e_tube[j] || r_time[b_rec + j] !== e_time[j] ||
                         r_last[b_rec + j] !== e_last[j]) begin
                if (bad == 0)
                    $display("FAIL %s rec %0d: got tube %0d time %h last %b expected tube %0d time %h last %b",
                             nm, j, r_tube[b_rec + j], r_time[b_rec + j], r_last[b_rec + j],
                             e_tube[j], e_time[j], e_last[j]);
                bad++;
            end
        end
        chk(nm, 32'(bad), 32'd0);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        int pat; int tg; int rst; int nrec; int ndone; int nerr; int nrd; int evc; int erc;
        logic [31:0] mask;
    } vec_t;

`ifdef ZERO_SUPPRESS_EN
    localparam int SPARSE_N = 3;
`else
    localparam int SPARSE_N = 32;
`endif

    vec_t vt [7];

    initial begin
        vt[0] = '{0, 0, 0, 0,        0, 0, 10, 0, 0, 32'h0000_0000};
        vt[1] = '{1, 0, 0, 32,       1, 0, 34, 1, 0, 32'hFFFF_FFFF};
        vt[2] = '{1, 1, 0, 32,       1, 0, 34, 2, 0, 32'hFFFF_FFFF};
        vt[3] = '{2, 0, 1, 1,        0, 1, 34, 0, 1, 32'h0000_0000};
        vt[4] = '{1, 0, 0, 32,       1, 0, 34, 1, 1, 32'hFFFF_FFFF};
        vt[5] = '{3, 1, 0, SPARSE_N, 1, 0, 34, 2, 1, 32'h0010_0008};
        vt[6] = '{4, 0, 0, 48,       1, 1, 50, 3, 2, 32'hFFFF_FFFF};

        repeat (3) @(negedge clk);
        chk("rst_hit_valid", 32'(hit_valid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_evt_done", 32'(evt_done), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        chk("rst_evt_count", 32'(evt_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_evt_mask", evt_mask, 32'd0);
        clr_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            if (vt[v].rst != 0) do_reset();
            tog = vt[v].tg;
            snap();
            gen(vt[v].pat);
            drain();
            chk($sformatf("v%0d_nrec", v), 32'(nrec - b_rec), 32'(vt[v].nrec));
            chk($sformatf("v%0d_evt_done", v), 32'(ndone - b_done), 32'(vt[v].ndone));
            chk($sformatf("v%0d_seq_err", v), 32'(nerr - b_err), 32'(vt[v].nerr));
            chk($sformatf("v%0d_reads", v), 32'(nrd - b_rd), 32'(vt[v].nrd));
            chk($sformatf("v%0d_evt_count", v), 32'(evt_count), 32'(vt[v].evc));
            chk($sformatf("v%0d_err_count", v), 32'(err_count), 32'(vt[v].erc));
            chk($sformatf("v%0d_evt_mask", v), evt_mask, vt[v].mask);
            chk_records($sformatf("v%0d_records", v));
        end

        // FIFO runs dry mid-event: the reader waits, then finishes the event
        tog = 0;
        snap();
        ne = 0;
        push_word(16'h00FF);
        clean_event(0, 10);
        repeat (40) @(negedge clk);
        chk("stall_no_done", 32'(ndone - b_done), 32'd0);
        chk("stall_nrec", 32'(nrec - b_rec), 32'd10);
        clean_event(10, 32);
        drain();
        chk("stall_done", 32'(ndone - b_done), 32'd1);
        chk("stall_evt_count", 32'(evt_count), 32'd4);
        chk_records("stall_records");

        // Reset in the middle of an event discards it
        snap();
        ne = 0;
        push_word(16'h00FF);
        clean_event(0, 16);
        begin
            int c = 0;
            while (nrec - b_rec < 16 && c < 500) begin
                @(negedge clk);
                c++;
            end
        end
        chk("mid_rst_partial_recs", 32'(nrec - b_rec), 32'd16);
        clr_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_evt_count", 32'(evt_count), 32'd0);
        chk("mid_rst_evt_mask", evt_mask, 32'd0);
        chk("mid_rst_hit_valid", 32'(hit_valid), 32'd0);
        clr_n = 1'b1;
        @(negedge clk);
        snap();
        gen(1);
        drain();
        chk("post_rst_done", 32'(ndone - b_done), 32'd1);
        chk("post_rst_seq_err", 32'(nerr - b_err), 32'd0);
        chk("post_rst_evt_count", 32'(evt_count), 32'd1);
        chk("post_rst_err_count", 32'(err_count), 32'd0);
        chk("post_rst_evt_mask", evt_mask, 32'hFFFF_FFFF);
        chk_records("post_rst_records");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
